// File: rtl/basic_ram_pkg.sv
// Shared constants and FSM state type for the basic RAM sequencing controller.
package basic_ram_pkg;

    localparam int DATA_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HALF    = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/nibble_pair_packer.sv
// Packs two consecutive accepted nibbles into the din1/din2 word pair held for the RAM.
module nibble_pair_packer import basic_ram_pkg::*; #(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              second,
    input  logic [DATA_W-1:0] nibble,
    output logic [DATA_W-1:0] din1,
    output logic [DATA_W-1:0] din2
);

    // The first nibble of a pair lands in din1, the second in din2; both hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din1 <= '0;
            din2 <= '0;
        end else if (accept) begin
            if (second) begin
                din2 <= nibble;
            end else begin
                din1 <= nibble;
            end
        end
    end

endmodule

// File: rtl/basic_ram_ctrl.sv
// Nibble-packing write sequencer and single-shot read-back path for the dual-word RAM.
// Optional read-back compare against the last written pair: define BASIC_RAM_RDCHK_EN.
module basic_ram_ctrl import basic_ram_pkg::*; #(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rd_req,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [DATA_W-1:0] ram_din1,
    output logic [DATA_W-1:0] ram_din2,
    input  logic [DATA_W-1:0] ram_dout1,
    input  logic [DATA_W-1:0] ram_dout2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    input  logic              out_ready,
    output logic              mismatch
);

    // state   | meaning
    // IDLE    | waiting for first nibble or pending read
    // HALF    | din1 loaded, waiting for second nibble
    // WRITE   | one-cycle write strobe of the packed pair
    // READ    | one-cycle read strobe
    // CAPTURE | RAM read data settling, latched at end of cycle
    // RESP    | read-back pair offered until out_ready

    state_t state_q, state_d;
    logic   rd_pend_q;
    logic   accept;

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HALF;
                end else if (rd_pend_q) begin
                    state_d = READ;
                end
            end
            HALF:    if (accept) state_d = WRITE;
            WRITE:   state_d = IDLE;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and ready/valid are decoded from the next state so they are glitch-free
    // registers that coincide exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_pend_q <= 1'b0;
            in_ready  <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= (state_d == READ) ? 1'b0 : (rd_pend_q | rd_req);
            in_ready  <= (state_d == IDLE) || (state_d == HALF);
            ram_cs    <= (state_d == WRITE) || (state_d == READ);
            ram_we    <= (state_d == WRITE);
            ram_oe    <= (state_d == READ);
            out_valid <= (state_d == RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data1 <= '0;
            out_data2 <= '0;
        end else if (state_q == CAPTURE) begin
            out_data1 <= ram_dout1;
            out_data2 <= ram_dout2;
        end
    end

    nibble_pair_packer #(.DATA_W(DATA_W)) u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .second (state_q == HALF),
        .nibble (in_data),
        .din1   (ram_din1),
        .din2   (ram_din2)
    );

`ifdef BASIC_RAM_RDCHK_EN
    logic [DATA_W-1:0] shadow1_q, shadow2_q;
    logic              shadow_vld_q;
    logic              mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow1_q    <= '0;
            shadow2_q    <= '0;
            shadow_vld_q <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            if (state_q == WRITE) begin
                shadow1_q    <= ram_din1;
                shadow2_q    <= ram_din2;
                shadow_vld_q <= 1'b1;
            end
            // A read before the first write has nothing meaningful to compare against.
            if ((state_q == CAPTURE) && shadow_vld_q &&
                ((ram_dout1 != shadow1_q) || (ram_dout2 != shadow2_q))) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: doc/basic_ram_ctrl.md
# basic_ram_ctrl

Sequencing stage directly upstream of the 4-bit dual-word basic RAM. It accepts a valid/ready stream of 4-bit nibbles, packs consecutive nibbles into a word pair, and issues a one-cycle write strobe (cs/we) carrying both words. On request, it issues a read strobe (cs/oe), captures the registered read-back pair, and returns it on a valid/ready response port.

## Interface
- DATA_W, 4, nibble/word width; must equal the RAM data width
- clk  input  1  rising-edge clock, shared with the RAM
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream nibble valid
- in_data  input  DATA_W  upstream nibble
- in_ready  output  1  nibble accepted when in_valid & in_ready at posedge
- rd_req  input  1  single-cycle read request pulse
- ram_cs  output  1  RAM chip select
- ram_we  output  1  RAM write enable
- ram_oe  output  1  RAM output enable
- ram_din1  output  DATA_W  word 0 to RAM
- ram_din2  output  DATA_W  word 1 to RAM
- ram_dout1  input  DATA_W  word 0 from RAM (registered in RAM)
- ram_dout2  input  DATA_W  word 1 from RAM
- out_valid  output  1  read-back pair valid
- out_data1  output  DATA_W  read-back word 0
- out_data2  output  DATA_W  read-back word 1
- out_ready  input  1  consumer accepts pair when out_valid & out_ready
- mismatch  output  1  sticky compare error (only with BASIC_RAM_RDCHK_EN)

## Operation
- All outputs reset to 0; state = IDLE; pending-read flag cleared; any half-packed nibble discarded.
- FSM states: IDLE, HALF, WRITE, READ, CAPTURE, RESP.
- IDLE: in_ready=1. An accepted nibble goes to ram_din1 and the FSM moves to HALF. Otherwise, if a read is pending, the FSM moves to READ.
- HALF: in_ready=1. An accepted nibble goes to ram_din2 and the FSM moves to WRITE.
- WRITE: ram_cs=1, ram_we=1, ram_oe=0 for exactly one cycle; in_ready=0; next state IDLE.
- READ: ram_cs=1, ram_we=0, ram_oe=1 for exactly one cycle; next state CAPTURE.
- CAPTURE: latch ram_dout1/2 into out_data1/2; next state RESP.
- RESP: out_valid=1 and out_data held stable until out_ready; on the handshake, out_valid drops and the FSM returns to IDLE. in_ready=0 throughout READ, CAPTURE and RESP.
- rd_req is latched into the pending flag in any state. Further pulses while the flag is set merge into it. The flag clears on entry to READ.
- Simultaneous rd_req and nibble in IDLE: the nibble wins, and the read stays pending until the pair is written.
- The FSM never serves a read while in HALF, so a half-packed pair is never read.
- ram_cs/we/oe are registered and never asserted together with both we and oe.
- ram_din1/2 hold their values outside WRITE.

## Timing
- Write latency: second nibble accepted at edge N; WRITE strobe high during cycle N+1; RAM stores at edge N+2.
- Read latency: READ strobe during cycle R; RAM dout valid after edge R+1; captured at edge R+2; out_valid high from R+2.
- Minimum gaps:
  - nibble-to-nibble throughput is 2 nibbles per 3 cycles;
  - read turnaround from entering READ to out_valid is 2 cycles.
- rst_n assertion mid-WRITE or mid-READ drops the strobes immediately (asynchronous); the RAM may or may not have sampled them.

## Configuration
- BASIC_RAM_RDCHK_EN defined:
  - the last written pair is shadowed;
  - in CAPTURE, the captured pair is compared against the shadow, and mismatch is set (sticky until reset) if they differ;
  - a read before any write does not compare.
- Not defined: no shadow registers; mismatch is tied to 0.

## Structure
- Package basic_ram_pkg holds: the DATA_W default constant and the state enum typedef (state_t).
- One natural sub-module, nibble_pair_packer, covering the HALF/IDLE packing and the din1/din2 registers. The FSM stays in basic_ram_ctrl.

## Test plan
- Reset, then nibbles 0x3, 0xA → one WRITE cycle with din1=0x3, din2=0xA, cs=1, we=1, oe=0; in_ready low that cycle only.
- After that write, pulse rd_req with out_ready=1 → READ strobe, then out_valid 2 cycles later with out_data1=0x3, out_data2=0xA for one cycle.
- rd_req in the same cycle as the first nibble 0x5, then 0x6 → WRITE(0x5,0x6) precedes READ, and read-back returns 0x5/0x6.
- out_ready=0 for 5 cycles in RESP → out_valid and out_data stable; in_ready=0; a new rd_req pulse is held pending and served after the handshake.
- With BASIC_RAM_RDCHK_EN, force ram_dout1=0xF against written 0x3 → mismatch=1 and stays set until rst_n low.
- rst_n low during READ → all outputs 0 at once; pending flag cleared; after release, a single nibble does not trigger WRITE.
